// File: rtl/vram_write_buffer.sv
// Write buffer between the rasterizer VRAM write port and the memory controller:
// FIFO plus one output stage replayed over req/ack. Optional VRAM_WRITE_COALESCE_EN merges same-address writes.
module vram_write_buffer #(
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int MASK_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                      clk,
    input  logic                      reset_ni,
    input  logic                      vram_sel_i,
    input  logic                      vram_wr_i,
    input  logic [MASK_WIDTH-1:0]     vram_mask_i,
    input  logic [ADDR_WIDTH-1:0]     vram_addr_i,
    input  logic [DATA_WIDTH-1:0]     vram_data_i,
    output logic                      full_o,
    output logic                      afull_o,
    output logic                      overflow_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      idle_o,
    output logic                      mem_req_o,
    input  logic                      mem_ack_i,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_data_o,
    output logic [MASK_WIDTH-1:0]     mem_mask_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [MASK_WIDTH-1:0] mask;
    } entry_t;

    typedef enum logic {S_EMPTY, S_REQ} state_t;

    state_t           r_state, w_state_nxt;
    entry_t           r_mem [DEPTH];
    entry_t           r_out, w_out_nxt, w_in, w_head, w_mem_wr_data;
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_mem_wr_ptr;
    logic [LVL_W-1:0] r_cnt, w_cnt_nxt, r_level, w_level_nxt;
    logic             w_wr, w_complete, w_push, w_pop, w_merge, w_drop;
    logic             r_full, r_afull, r_overflow;

    assign w_wr       = vram_sel_i & vram_wr_i;
    assign w_in       = '{addr: vram_addr_i, data: vram_data_i, mask: vram_mask_i};
    assign w_complete = (r_state == S_REQ) & mem_ack_i;
    assign w_head     = r_mem[r_rd_ptr];

`ifdef VRAM_WRITE_COALESCE_EN
    localparam int LANE_W = DATA_WIDTH / MASK_WIDTH;
    logic [PTR_W-1:0] w_tail_ptr;
    entry_t           w_tail, w_merged;

    assign w_tail_ptr = r_wr_ptr - 1'b1;
    assign w_tail     = r_mem[w_tail_ptr];
    // The tail must survive this edge in the FIFO; a lone entry being popped is no longer mergeable.
    assign w_merge    = w_wr && (r_cnt != '0) && !(w_complete && (r_cnt == LVL_W'(1)))
                        && (w_tail.addr == w_in.addr);

    always_comb begin
        w_merged      = w_tail;
        w_merged.mask = w_tail.mask | w_in.mask;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if (w_in.mask[i]) w_merged.data[i*LANE_W +: LANE_W] = w_in.data[i*LANE_W +: LANE_W];
        end
    end

    assign w_mem_wr_ptr  = w_merge ? w_tail_ptr : r_wr_ptr;
    assign w_mem_wr_data = w_merge ? w_merged : w_in;
`else
    assign w_merge       = 1'b0;
    assign w_mem_wr_ptr  = r_wr_ptr;
    assign w_mem_wr_data = w_in;
`endif

    // NOTE: every signal gets its default before the case, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_wr) begin
                    w_out_nxt   = w_in;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_complete) begin
                    if (r_cnt != '0) begin
                        w_out_nxt = w_head;
                        w_pop     = 1'b1;
                        w_push    = w_wr & ~w_merge;
                    end else if (w_wr) begin
                        w_out_nxt = w_in;
                    end else begin
                        w_state_nxt = S_EMPTY;
                    end
                end else if (w_wr && !w_merge) begin
                    if (r_cnt == LVL_W'(DEPTH)) w_drop = 1'b1;
                    else                         w_push = 1'b1;
                end
            end
        endcase
    end

    assign w_cnt_nxt   = r_cnt + LVL_W'(w_push) - LVL_W'(w_pop);
    assign w_level_nxt = w_cnt_nxt + LVL_W'(w_state_nxt == S_REQ);

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= S_EMPTY;
            r_out      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_out      <= w_out_nxt;
            r_wr_ptr   <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr   <= r_rd_ptr + PTR_W'(w_pop);
            r_cnt      <= w_cnt_nxt;
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == LVL_W'(DEPTH + 1));
            r_afull    <= (w_level_nxt >= LVL_W'(AFULL_LEVEL));
            r_overflow <= r_overflow | w_drop;
        end
    end

    // NOTE: storage has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push || w_merge) r_mem[w_mem_wr_ptr] <= w_mem_wr_data;
    end

    assign mem_req_o  = (r_state == S_REQ);
    assign mem_addr_o = r_out.addr;
    assign mem_data_o = r_out.data;
    assign mem_mask_o = r_out.mask;
    assign level_o    = r_level;
    assign full_o     = r_full;
    assign afull_o    = r_afull;
    assign overflow_o = r_overflow;
    assign idle_o     = (r_level == '0) & ~mem_req_o;
endmodule

// File: tb/tb_vram_write_buffer.sv
// Bench for vram_write_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vram_write_buffer;
    localparam int DEPTH = 16, AW = 16, DW = 16, MW = 4, AFULL = 12;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic          vram_sel_i = 1'b0, vram_wr_i = 1'b0, mem_ack_i = 1'b0;
    logic [MW-1:0] vram_mask_i = '0;
    logic [AW-1:0] vram_addr_i = '0;
    logic [DW-1:0] vram_data_i = '0;
    logic          full_o, afull_o, overflow_o, idle_o, mem_req_o;
    logic [LW-1:0] level_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [MW-1:0] mem_mask_o;

    always #5 clk = ~clk;

    vram_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .MASK_WIDTH(MW), .AFULL_LEVEL(AFULL)) dut (
        .clk(clk), .reset_ni(reset_ni),
        .vram_sel_i(vram_sel_i), .vram_wr_i(vram_wr_i), .vram_mask_i(vram_mask_i),
        .vram_addr_i(vram_addr_i), .vram_data_i(vram_data_i),
        .full_o(full_o), .afull_o(afull_o), .overflow_o(overflow_o), .level_o(level_o),
        .idle_o(idle_o), .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o)
    );

    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: output stage plus an unbounded-view queue limited to DEPTH.
    bit   m_out_valid = 0;
    ent_t m_out;
    ent_t m_q[$];
    bit   m_ovf = 0;
    ent_t got_q[$];
    bit   seen_full = 0;

    always @(posedge clk or negedge reset_ni) begin : model
        ent_t w;
        logic [DW-1:0] bm;
        if (!reset_ni) begin
            m_out_valid = 0;
            m_q.delete();
            m_ovf = 0;
        end else begin
            w = '{vram_addr_i, vram_data_i, vram_mask_i};
            if (m_out_valid && mem_ack_i) begin
                if (m_q.size() > 0) m_out = m_q.pop_front();
                else m_out_valid = 0;
            end
            if (vram_sel_i && vram_wr_i) begin
                if (!m_out_valid) begin
                    m_out = w;
                    m_out_valid = 1;
                end
`ifdef VRAM_WRITE_COALESCE_EN
                else if (m_q.size() > 0 && m_q[m_q.size()-1].addr == w.addr) begin
                    bm = '0;
                    for (int i = 0; i < MW; i++) if (w.mask[i]) bm[i*(DW/MW) +: DW/MW] = '1;
                    m_q[m_q.size()-1].data = (m_q[m_q.size()-1].data & ~bm) | (w.data & bm);
                    m_q[m_q.size()-1].mask = m_q[m_q.size()-1].mask | w.mask;
                end
`endif
                else if (m_q.size() < DEPTH) m_q.push_back(w);
                else m_ovf = 1;
            end
        end
    end

    always @(posedge clk) begin
        if (reset_ni && mem_req_o && mem_ack_i) got_q.push_back('{mem_addr_o, mem_data_o, mem_mask_o});
    end

    always @(negedge clk) begin : compare
        int lvl;
        if (reset_ni === 1'b1) begin
            lvl = m_q.size() + int'(m_out_valid);
            if (full_o) seen_full = 1;
            check("mem_req_o", mem_req_o, m_out_valid);
            check("level_o", level_o, lvl);
            check("full_o", full_o, lvl == DEPTH + 1);
            check("afull_o", afull_o, lvl >= AFULL);
            check("overflow_o", overflow_o, m_ovf);
            check("idle_o", idle_o, lvl == 0);
            if (m_out_valid) begin
                check("mem_addr_o", mem_addr_o, m_out.addr);
                check("mem_data_o", mem_data_o, m_out.data);
                check("mem_mask_o", mem_mask_o, m_out.mask);
            end
        end
    end

    // Inputs change 2 time units after an edge and are captured by the next edge.
    task automatic put(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m, input bit k);
        @(posedge clk);
        #2;
        vram_sel_i  = w;
        vram_wr_i   = w;
        vram_addr_i = a;
        vram_data_i = d;
        vram_mask_i = m;
        mem_ack_i   = k;
    endtask

    task automatic idle(input int n, input bit k);
        for (int i = 0; i < n; i++) put(0, '0, '0, '0, k);
    endtask

    task automatic do_reset();
        put(0, '0, '0, '0, 0);
        reset_ni = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_ni = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int errs;
        int ackp;
        reset_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset mem_req_o", mem_req_o, 0);
        check("reset level_o", level_o, 0);
        check("reset idle_o", idle_o, 1);
        check("reset full_o", full_o, 0);
        check("reset overflow_o", overflow_o, 0);
        check("reset mem_addr_o", mem_addr_o, 0);
        #1;
        reset_ni = 1'b1;

        // Single write with ack held high.
        got_q.delete();
        put(1, 16'h0123, 16'hF0F0, 4'hF, 1);
        put(0, '0, '0, '0, 1);
        #1;
        check("single req high", mem_req_o, 1);
        check("single addr", mem_addr_o, 16'h0123);
        check("single data", mem_data_o, 16'hF0F0);
        check("single mask", mem_mask_o, 4'hF);
        put(0, '0, '0, '0, 1);
        #1;
        check("single req low", mem_req_o, 0);
        check("single idle", idle_o, 1);
        check("single count", got_q.size(), 1);

        // Clear sweep with ack held high.
        got_q.delete();
        seen_full = 0;
        for (int a = 0; a < 16384; a++) put(1, AW'(a), 16'hF00F, 4'hF, 1);
        idle(4, 1);
        check("sweep count", got_q.size(), 16384);
        errs = 0;
        foreach (got_q[i]) if (got_q[i].addr != AW'(i) || got_q[i].data != 16'hF00F) errs++;
        check("sweep order", errs, 0);
        check("sweep never full", seen_full, 0);
        check("sweep overflow", overflow_o, 0);

        // Fill to capacity, then overflow.
        do_reset();
        for (int a = 0; a < 17; a++) put(1, AW'(a), 16'h1000 + 16'(a), 4'hF, 0);
        put(0, '0, '0, '0, 0);
        #1;
        check("fill full_o", full_o, 1);
        check("fill level_o", level_o, 17);
        check("fill overflow_o", overflow_o, 0);
        put(1, 16'h0011, 16'hDEAD, 4'hF, 0);
        put(0, '0, '0, '0, 0);
        #1;
        check("drop overflow_o", overflow_o, 1);
        check("drop level_o", level_o, 17);
        got_q.delete();
        idle(20, 1);
        check("drain count", got_q.size(), 17);
        errs = 0;
        foreach (got_q[i]) if (got_q[i].addr != AW'(i)) errs++;
        check("drain order", errs, 0);
        check("drain overflow sticky", overflow_o, 1);

        // Full + write + completion on the same edge.
        do_reset();
        for (int a = 0; a < 17; a++) put(1, AW'(a), 16'h2000 + 16'(a), 4'hF, 0);
        got_q.delete();
        put(1, 16'h0099, 16'h9999, 4'hF, 1);
        put(0, '0, '0, '0, 0);
        #1;
        check("fullack level_o", level_o, 17);
        check("fullack overflow_o", overflow_o, 0);
        idle(20, 1);
        check("fullack count", got_q.size(), 18);
        check("fullack last addr", got_q[got_q.size()-1].addr, 16'h0099);

        // Reset in the middle of a transfer.
        do_reset();
        for (int a = 0; a < 6; a++) put(1, AW'(16'h40 + a), 16'h5555, 4'hF, 0);
        put(0, '0, '0, '0, 0);
        #1;
        check("pre-reset level_o", level_o, 6);
        reset_ni = 1'b0;
        #1;
        check("midreset mem_req_o", mem_req_o, 0);
        check("midreset level_o", level_o, 0);
        check("midreset idle_o", idle_o, 1);
        got_q.delete();
        @(posedge clk);
        #2;
        reset_ni = 1'b1;
        idle(10, 1);
        check("no stale requests", got_q.size(), 0);

        // Same-address pair behind a busy output stage.
        do_reset();
        put(1, 16'h0100, 16'h1111, 4'hF, 0);
        put(1, 16'h0200, 16'h000A, 4'h1, 0);
        put(1, 16'h0200, 16'h00B0, 4'h2, 0);
        put(0, '0, '0, '0, 0);
        #1;
        got_q.delete();
`ifdef VRAM_WRITE_COALESCE_EN
        check("coalesce level_o", level_o, 2);
        idle(6, 1);
        check("coalesce count", got_q.size(), 2);
        check("coalesce addr", got_q[1].addr, 16'h0200);
        check("coalesce data", got_q[1].data, 16'h00BA);
        check("coalesce mask", got_q[1].mask, 4'h3);
`else
        check("nocoalesce level_o", level_o, 3);
        idle(6, 1);
        check("nocoalesce count", got_q.size(), 3);
        check("nocoalesce 1st data", got_q[1].data, 16'h000A);
        check("nocoalesce 2nd addr", got_q[2].addr, 16'h0200);
        check("nocoalesce 2nd mask", got_q[2].mask, 4'h2);
`endif

        // Randomized traffic with shifting ack pressure.
        do_reset();
        ackp = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) ackp = (c / 500 % 3 == 0) ? 15 : ((c / 500 % 3 == 1) ? 90 : 50);
            if (c == 2000) do_reset();
            put($urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), DW'($urandom),
                MW'($urandom), $urandom_range(0, 99) < ackp);
        end
        idle(40, 1);
        #1;
        check("final idle_o", idle_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vram_write_buffer.md
Name: vram_write_buffer

Overview:
- Sits directly downstream of the graphite rasterizer's VRAM write port and upstream of the video memory controller.
- Captures every rasterizer write strobe (clear, line and triangle pixels) into a FIFO.
- Replays the buffered writes to memory over a req/ack handshake, so memory stalls do not drop pixels.
- Reports fill level, full/almost-full and a sticky overflow flag, for use as back-pressure or debug.

Parameters:
- DEPTH, 16: FIFO entries; power of two, 4..256.
- ADDR_WIDTH, 16: VRAM word address width.
- DATA_WIDTH, 16: VRAM word width.
- MASK_WIDTH, 4: write mask width; one bit per DATA_WIDTH/MASK_WIDTH-bit lane.
- AFULL_LEVEL, 12: level at or above which afull_o asserts.

Ports:
- clk  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- vram_sel_i  in  1  write select from rasterizer
- vram_wr_i  in  1  write strobe from rasterizer
- vram_mask_i  in  MASK_WIDTH  lane mask
- vram_addr_i  in  ADDR_WIDTH  word address
- vram_data_i  in  DATA_WIDTH  pixel data (ARGB4444)
- full_o  out  1  no free entry
- afull_o  out  1  level >= AFULL_LEVEL
- overflow_o  out  1  sticky; a write was dropped
- level_o  out  $clog2(DEPTH)+1  entries held, including the output stage
- idle_o  out  1  level_o==0 and mem_req_o==0
- mem_req_o  out  1  write request to memory
- mem_ack_i  in  1  memory accepts the current request
- mem_addr_o  out  ADDR_WIDTH  request address
- mem_data_o  out  DATA_WIDTH  request data
- mem_mask_o  out  MASK_WIDTH  request mask

Behaviour:
- Reset: one clock, asynchronous active-low reset reset_ni. On assertion, all outputs go to 0 immediately: mem_req_o, mem_addr_o, mem_data_o, mem_mask_o, full_o, afull_o, overflow_o, level_o. idle_o goes to 1. FIFO pointers are cleared. Reset mid-transfer abandons the in-flight request; mem_ack_i is ignored while in reset.
- Input accept: every rising edge with vram_sel_i & vram_wr_i high is one distinct write. There is no input handshake. Back-to-back cycles with sel/wr held high (the clear sweep) are separate writes.
- Storage: a DEPTH-entry circular FIFO of {addr,data,mask}, plus one registered output stage that drives the mem_* outputs. Capacity is DEPTH + 1; full_o means level_o == DEPTH+1.
- Output FSM states:
  - EMPTY: mem_req_o=0. On a write, the output stage loads the entry (FIFO bypass) and goes to REQ. mem_req_o rises one cycle after the write edge.
  - REQ: mem_req_o=1; mem_* outputs stay stable until handshake.
  - Handshake completes on an edge where mem_req_o & mem_ack_i are both high.
  - On completion, the output stage loads the FIFO head, or the incoming write if the FIFO is empty, and stays in REQ. Otherwise it goes to EMPTY.
  - Sustained throughput is 1 write/cycle with mem_ack_i held high.
- Ordering: strict FIFO order; no reordering.
- Full + write, no completion that cycle: the write is dropped and overflow_o sets. overflow_o stays set until reset.
- Full + write + completion in the same cycle: the write is accepted; level unchanged.
- Pointers: binary, wrap modulo DEPTH. level_o updates the cycle after each accept/complete. afull_o and full_o are registered, consistent with level_o.
- mem_ack_i while mem_req_o=0: ignored.

Optional Feature:
- Macro: VRAM_WRITE_COALESCE_EN.
- Defined: an accepted write whose addr equals the FIFO tail entry's addr merges into that entry instead of allocating a new one.
  - The tail entry is the most recent write still in the FIFO, not in the output stage.
  - For each set mask bit, the corresponding data lane is replaced; the stored mask becomes the OR of both masks.
  - level_o is unchanged.
  - The merge applies even when full (no overflow).
  - No merge with the output stage.
- Undefined: no address compare; every write allocates an entry.

Test Plan:
- Single write addr=0x0123 data=0xF0F0 mask=0xF, mem_ack_i=1 -> mem_req_o high exactly one cycle, starting one cycle after the strobe, with matching addr/data/mask; idle_o returns to 1.
- Clear sweep addr 0..16383 data=0xF00F, mem_ack_i=1 -> 16384 requests in address order; full_o never asserts; overflow_o stays 0.
- mem_ack_i=0, 17 writes at addr 0..16 -> full_o=1, level_o=17; 18th write dropped, overflow_o=1. Then ack -> exactly addrs 0..16 emitted in order.
- Full + write + ack on the same edge -> level_o stays 17; new entry emitted last; overflow_o stays 0.
- Assert reset_ni low while mem_req_o=1 with 5 entries queued -> mem_req_o=0 and level_o=0 immediately; after release, no stale requests.
- VRAM_WRITE_COALESCE_EN defined, ack held low, one write to 0x0100 to fill the output stage, then writes to 0x0200 mask=0x1 data=0x000A and 0x0200 mask=0x2 data=0x00B0 -> level_o=2; second memory request addr=0x0200 data=0x00BA mask=0x3. Undefined -> level_o=3, two separate 0x0200 requests.
